// File: rtl/exe_div_ctrl_pkg.sv
// Shared types and constants for the exe-stage RV64M divide controller.
// Op-bit layout, FSM states, iteration counts and operand-shaping helpers.
package exe_div_ctrl_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  // Mirrors the div_op bus: [2]=word, [1]=remainder, [0]=unsigned
  typedef struct packed {
    logic is_word;
    logic is_rem;
    logic is_unsigned;
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [CNT_W-1:0] DIV_ITER_64 = CNT_W'(64);
  localparam logic [CNT_W-1:0] DIV_ITER_32 = CNT_W'(32);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WORD_MIN = {{(XLEN-31){1'b1}}, 31'b0};

  function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] v,
                                                   input logic word,
                                                   input logic uns);
    logic [XLEN-1:0] r;
    if (!word)    r = v;
    else if (uns) r = {32'b0, v[31:0]};
    else          r = {{32{v[31]}}, v[31:0]};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/exe_div_ctrl_if.sv
// Exe-stage <-> divider handshake: op request, flush, stall and result.
// master = exe stage, slave = divide controller.
interface exe_div_ctrl_if;
  import exe_div_ctrl_pkg::*;

  logic            div_start;
  div_op_t         div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            res_valid;
  logic [XLEN-1:0] res;

  modport master (
    output div_start, div_op, dividend, divisor, flush,
    input  busy, stall_req, res_valid, res
  );

  modport slave (
    input  div_start, div_op, dividend, divisor, flush,
    output busy, stall_req, res_valid, res
  );

endinterface

// File: rtl/exe_div_ctrl_iter_core.sv
// Restoring divider datapath: one subtract-and-shift per enable on unsigned magnitudes.
// Word loads pre-shift the dividend so 32 steps leave the quotient in the low half.
module exe_div_ctrl_iter_core
  import exe_div_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            enable,
  input  logic [XLEN-1:0] a_abs,
  input  logic [XLEN-1:0] b_abs,
  input  logic            word,
  output logic [XLEN-1:0] quo_raw,
  output logic [XLEN-1:0] rem_raw
);

  logic [XLEN-1:0] rem_q, quo_q, b_q;
  logic [XLEN:0]   partial;
  logic            fits;
  logic [XLEN-1:0] rem_sub;

  // Partial remainder is 2*rem+bit < 2*b, so one extra bit suffices
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign fits    = (partial >= {1'b0, b_q});
  assign rem_sub = partial[XLEN-1:0] - b_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      b_q   <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= word ? {a_abs[31:0], 32'b0} : a_abs;
      b_q   <= word ? {32'b0, b_abs[31:0]} : b_abs;
    end else if (enable) begin
      rem_q <= fits ? rem_sub : partial[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
    end
  end

  assign quo_raw = quo_q;
  assign rem_raw = rem_q;

endmodule

// File: rtl/exe_div_ctrl.sv
// RV64M divide sequencer: N+1 cycles (N=64, 32 for W), 1 cycle for /0 and MIN/-1.
// Holds the pipeline via stall_req until DONE; flush aborts, divider never back-pressured.
module exe_div_ctrl
  import exe_div_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  exe_div_ctrl_if.slave div_if
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  div_op_t          op_q;
  logic [XLEN-1:0]  a_q, res_q, res_calc;
  logic             a_neg_q, b_neg_q, zero_q, ovf_q;

  logic             start, core_load, core_en;
  logic [XLEN-1:0]  a_ext, b_ext, a_abs, b_abs, quo_raw, rem_raw;
  logic             a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0]  quo_fix, rem_fix, res_sel;

  assign start = (state_q == DIV_IDLE) && div_if.div_start && !div_if.flush;

  assign a_ext = ext_operand(div_if.dividend, div_if.div_op.is_word, div_if.div_op.is_unsigned);
  assign b_ext = ext_operand(div_if.divisor,  div_if.div_op.is_word, div_if.div_op.is_unsigned);
  assign a_neg = !div_if.div_op.is_unsigned && a_ext[XLEN-1];
  assign b_neg = !div_if.div_op.is_unsigned && b_ext[XLEN-1];
  assign a_abs = a_neg ? -a_ext : a_ext;
  assign b_abs = b_neg ? -b_ext : b_ext;

  // W operands are already sign-extended, so both widths compare against a 64-bit MIN
  assign div_zero = (b_ext == '0);
  assign ovf      = !div_if.div_op.is_unsigned && (b_ext == '1) &&
                    (a_ext == (div_if.div_op.is_word ? WORD_MIN : XLEN_MIN));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    core_load = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          core_load = 1'b1;
          if (div_zero || ovf) begin
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_CALC;
            cnt_d   = div_if.div_op.is_word ? DIV_ITER_32 : DIV_ITER_64;
          end
        end
      end
      DIV_CALC: begin
        core_en = 1'b1;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (div_if.flush) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        op_q    <= div_if.div_op;
        a_q     <= a_ext;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        zero_q  <= div_zero;
        ovf_q   <= ovf;
      end
      if (state_q == DIV_DONE) res_q <= res_calc;
    end
  end

  exe_div_ctrl_iter_core u_core (
    .clock   (clock),
    .reset   (reset),
    .load    (core_load),
    .enable  (core_en),
    .a_abs   (a_abs),
    .b_abs   (b_abs),
    .word    (div_if.div_op.is_word),
    .quo_raw (quo_raw),
    .rem_raw (rem_raw)
  );

  // Quotient sign follows sign(a)^sign(b); remainder follows sign(a)
  always_comb begin
    if (zero_q)                quo_fix = '1;
    else if (ovf_q)            quo_fix = a_q;
    else if (a_neg_q ^ b_neg_q) quo_fix = -quo_raw;
    else                       quo_fix = quo_raw;

    if (zero_q)       rem_fix = a_q;
    else if (ovf_q)   rem_fix = '0;
    else if (a_neg_q) rem_fix = -rem_raw;
    else              rem_fix = rem_raw;

    res_sel  = op_q.is_rem ? rem_fix : quo_fix;
    res_calc = op_q.is_word ? sext_word(res_sel[31:0]) : res_sel;
  end

  assign div_if.busy      = (state_q != DIV_IDLE);
  assign div_if.stall_req = start || (state_q == DIV_CALC);
  assign div_if.res_valid = (state_q == DIV_DONE);
  assign div_if.res       = (state_q == DIV_DONE) ? res_calc : res_q;

  a_no_start_while_busy: assert property (@(posedge clock) disable iff (reset)
    !(div_if.busy && div_if.div_start));

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed bench for exe_div_ctrl: arithmetic reference model with per-cycle compare
// of busy/stall_req/res_valid/res, plus literal result and latency expectations.
module tb_exe_div_ctrl;

  localparam logic [2:0] OP_DIV   = 3'b000, OP_DIVU  = 3'b001, OP_REM   = 3'b010, OP_REMU  = 3'b011;
  localparam logic [2:0] OP_DIVW  = 3'b100, OP_DIVUW = 3'b101, OP_REMW  = 3'b110, OP_REMUW = 3'b111;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model of the op in flight
  int          m_s = -10, m_e = -10, m_kill = 1 << 30;
  bit          m_fast = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] hold = '0;
  bit          rst_seen = 1'b0;
  bit          e_valid, e_busy, e_stall;

  exe_div_ctrl_if dif ();

  exe_div_ctrl dut (
    .clock  (clk),
    .reset  (reset),
    .div_if (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0]        r32;
    logic signed [31:0] sa32, sb32;
    logic [63:0]        r;
    logic signed [63:0] sa, sb;
    if (op[2]) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'h0)                                    r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (op[0])                                          r32 = op[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : 32'h8000_0000;
      else if (op[1])                                          r32 = sa32 % sb32;
      else                                                     r32 = sa32 / sb32;
      return {{32{r32[31]}}, r32};
    end
    sa = a;
    sb = b;
    if (b == 64'h0)                                      r = op[1] ? a : ONES;
    else if (op[0])                                      r = op[1] ? a % b : a / b;
    else if (a == 64'h8000_0000_0000_0000 && b == ONES)  r = op[1] ? 64'h0 : a;
    else if (op[1])                                      r = sa % sb;
    else                                                 r = sa / sb;
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2])
      return (b[31:0] == 32'h0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == ONES);
  endfunction

  // Per-cycle compare against the model timeline
  always @(negedge clk) begin
    if (rst_seen) begin
      hold     = '0;
      rst_seen = 1'b0;
    end
    if (!reset && cyc > 0) begin
      e_valid = (cyc == m_e) && (cyc <= m_kill);
      e_busy  = (cyc > m_s) && (cyc <= m_e) && (cyc <= m_kill);
      e_stall = (cyc == m_s) || (!m_fast && cyc > m_s && cyc < m_e && cyc <= m_kill);
      chk("busy", {63'b0, dif.busy}, {63'b0, e_busy});
      chk("stall_req", {63'b0, dif.stall_req}, {63'b0, e_stall});
      chk("res_valid", {63'b0, dif.res_valid}, {63'b0, e_valid});
      if (e_valid) begin
        chk("res", dif.res, m_res);
        hold = m_res;
      end else begin
        chk("res_hold", dif.res, hold);
      end
    end
    if (reset) rst_seen = 1'b1;
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the start
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    dif.div_start = 1'b1;
    dif.div_op    = op;
    dif.dividend  = a;
    dif.divisor   = b;
    m_s    = cyc;
    m_fast = is_fast(op, a, b);
    m_e    = cyc + (m_fast ? 1 : (op[2] ? 33 : 65));
    m_kill = 1 << 30;
    m_res  = model(op, a, b);
    @(negedge clk);
    chk("start_busy", {63'b0, dif.busy}, 64'd0);
    chk("start_stall", {63'b0, dif.stall_req}, 64'd1);
    @(posedge clk);
    #1;
    dif.div_start = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int lat, input logic [63:0] exp);
    int t0 = m_s;
    int tv = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dif.res_valid) begin
        tv = cyc;
        break;
      end
    end
    chk({nm, "_lat"}, 64'(tv - t0), 64'(lat));
    chk(nm, dif.res, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic op_lit(input string nm, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int lat, input logic [63:0] exp);
    issue(op, a, b);
    wait_result(nm, lat, exp);
  endtask

  initial begin
    dif.div_start = 1'b0;
    dif.div_op    = 3'b000;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'b0, dif.busy}, 64'd0);
    chk("rst_stall", {63'b0, dif.stall_req}, 64'd0);
    chk("rst_valid", {63'b0, dif.res_valid}, 64'd0);
    chk("rst_res", dif.res, 64'd0);
    @(posedge clk);
    #1;

    op_lit("divu_100_7",  OP_DIVU, 64'd100, 64'd7, 65, 64'd14);
    op_lit("remu_100_7",  OP_REMU, 64'd100, 64'd7, 65, 64'd2);
    op_lit("div_m7_2",    OP_DIV,  -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    op_lit("rem_m7_2",    OP_REM,  -64'sd7, 64'd2, 65, ONES);
    op_lit("div_7_m2",    OP_DIV,  64'd7, -64'sd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    op_lit("rem_7_m2",    OP_REM,  64'd7, -64'sd2, 65, 64'd1);
    op_lit("divu_big",    OP_DIVU, ONES, 64'h10, 65, 64'h0FFF_FFFF_FFFF_FFFF);
    op_lit("divu_0_5",    OP_DIVU, 64'd0, 64'd5, 65, 64'd0);
    op_lit("div_5_0",     OP_DIV,  64'd5, 64'd0, 1, ONES);
    op_lit("remu_5_0",    OP_REMU, 64'd5, 64'd0, 1, 64'd5);
    op_lit("div_ovf",     OP_DIV,  64'h8000_0000_0000_0000, ONES, 1, 64'h8000_0000_0000_0000);
    op_lit("rem_ovf",     OP_REM,  64'h8000_0000_0000_0000, ONES, 1, 64'd0);
    op_lit("divw_ovf",    OP_DIVW, 64'h0000_0000_8000_0000, ONES, 1, 64'hFFFF_FFFF_8000_0000);
    op_lit("divuw_ones",  OP_DIVUW, 64'h1_FFFF_FFFF, 64'd1, 33, ONES);
    op_lit("remw_m9_4",   OP_REMW, -64'sd9, 64'd4, 33, ONES);
    op_lit("divw_hi_junk", OP_DIVW, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    op_lit("remuw_7fff",  OP_REMUW, 64'hFFFF_FFFF, 64'h8000_0000, 33, 64'h7FFF_FFFF);
    op_lit("divuw_fffe",  OP_DIVUW, 64'hFFFF_FFFE, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFE);
    op_lit("remw_by_0",   OP_REMW, 64'h1234_0000_8000_0000, 64'hABCD_0000_0000_0000, 1, 64'hFFFF_FFFF_8000_0000);

    // Flush mid-CALC, then a fresh op in the following cycle
    issue(OP_DIVU, 64'd1000, 64'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    dif.flush = 1'b1;
    m_kill    = cyc;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    chk("flush_gap", 64'(cyc - m_s), 64'd11);
    op_lit("divu_9_3_after_flush", OP_DIVU, 64'd9, 64'd3, 65, 64'd3);

    // Flush landing on DONE still shows the result that cycle
    issue(OP_DIV, 64'd5, 64'd0);
    dif.flush = 1'b1;
    m_kill    = cyc;
    @(negedge clk);
    chk("flush_done_valid", {63'b0, dif.res_valid}, 64'd1);
    chk("flush_done_res", dif.res, ONES);
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    @(negedge clk);
    chk("flush_done_busy", {63'b0, dif.busy}, 64'd0);
    @(posedge clk);
    #1;

    // start together with flush is ignored
    dif.div_start = 1'b1;
    dif.flush     = 1'b1;
    dif.div_op    = OP_DIVU;
    dif.dividend  = 64'd50;
    dif.divisor   = 64'd5;
    @(negedge clk);
    chk("start_flush_stall", {63'b0, dif.stall_req}, 64'd0);
    @(posedge clk);
    #1;
    dif.div_start = 1'b0;
    dif.flush     = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", {63'b0, dif.busy}, 64'd0);
    @(posedge clk);
    #1;

    // Reset at cycle 20 of an op
    issue(OP_DIVU, 64'd777, 64'd5);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    reset  = 1'b1;
    m_kill = cyc;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {63'b0, dif.busy}, 64'd0);
    chk("rst_mid_valid", {63'b0, dif.res_valid}, 64'd0);
    chk("rst_mid_res", dif.res, 64'd0);
    @(posedge clk);
    #1;
    op_lit("divu_after_rst", OP_DIVU, 64'd777, 64'd5, 65, 64'd155);
    op_lit("remu_after_rst", OP_REMU, 64'd777, 64'd5, 65, 64'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
